// File: rtl/ear_input_conditioner_if.sv
// Purpose: groups the EAR pin, the count-clear control and the conditioned outputs.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the signals are levels and pulses without a handshake.
interface ear_input_conditioner_if;
  logic        ear_pin;       // raw EAR pin, asynchronous to clk28
  logic        clear_count;   // synchronous clear of both event counters
  logic        ear_out;       // filtered EAR level
  logic        ear_edge;      // one-cycle pulse per accepted transition
  logic [15:0] edge_count;    // accepted transitions, wraps
  logic [7:0]  glitch_count;  // rejected pulses, saturates
  logic        activity;      // stretched "edge seen recently" flag

  // Board / environment side: drives the pin and the clear, observes results.
  modport master (
    output ear_pin,
    output clear_count,
    input  ear_out,
    input  ear_edge,
    input  edge_count,
    input  glitch_count,
    input  activity
  );

  // Conditioner side.
  modport slave (
    input  ear_pin,
    input  clear_count,
    output ear_out,
    output ear_edge,
    output edge_count,
    output glitch_count,
    output activity
  );
endinterface

// File: rtl/ear_input_conditioner.sv
// Purpose: synchronise, invert and deglitch the tape EAR pin; count edges and glitches; drive an activity flag.
// Latency: a clean pin step reaches ear_out/ear_edge FILTER_CYCLES+2 clk28 edges after it is first captured.
// Backpressure: none; the output is a level that always follows the pin after filtering.
module ear_input_conditioner #(
  parameter bit INVERT        = 1'b1,
  parameter int FILTER_CYCLES = 8,
  parameter int ACT_HOLD_BITS = 22
) (
  input logic                    clk28,
  input logic                    rst,
  ear_input_conditioner_if.slave io_ear
);

  // The filter counter only ever reaches FILTER_CYCLES-1, one spare bit keeps
  // the width legal for FILTER_CYCLES=1.
  localparam int FCNT_W = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  // Activity counter parks with only its msb set: that is "no recent edge".
  localparam logic [ACT_HOLD_BITS-1:0] ACNT_ONE  = ACT_HOLD_BITS'(1);
  localparam logic [ACT_HOLD_BITS-1:0] ACNT_IDLE = {1'b1, {(ACT_HOLD_BITS-1){1'b0}}};

  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_ear_out;
  logic                     r_ear_edge;
  logic [FCNT_W-1:0]        r_fcnt;
  logic [15:0]              r_edge_count;
  logic [7:0]               r_glitch_count;
  logic [ACT_HOLD_BITS-1:0] r_acnt;

  logic w_s;
  logic w_mismatch;
  logic w_accept;
  logic w_glitch;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= io_ear.ear_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Board inversion sits after the synchroniser so the flops see the raw pin.
  assign w_s        = INVERT ? ~r_sync2 : r_sync2;
  assign w_mismatch = w_s ^ r_ear_out;
  // Last cycle of a long-enough run: the new level is taken now.
  assign w_accept   = w_mismatch && (r_fcnt == FCNT_LAST);
  // Level fell back to ear_out after a partial run: that run was a glitch.
  assign w_glitch   = !w_mismatch && (r_fcnt != '0);

  // Deglitch filter: a level must disagree with ear_out for FILTER_CYCLES consecutive cycles.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_ear_out  <= 1'b0;
      r_ear_edge <= 1'b0;
      r_fcnt     <= '0;
    end else if (w_accept) begin
      r_ear_out  <= w_s;
      r_ear_edge <= 1'b1;
      r_fcnt     <= '0;
    end else if (w_mismatch) begin
      r_ear_edge <= 1'b0;
      r_fcnt     <= r_fcnt + FCNT_ONE;
    end else begin
      r_ear_edge <= 1'b0;
      r_fcnt     <= '0;
    end
  end

  // Accepted-edge counter; counts the registered edge pulse, clear has priority.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_edge_count <= 16'd0;
    end else if (io_ear.clear_count) begin
      r_edge_count <= 16'd0;
    end else if (r_ear_edge) begin
      r_edge_count <= r_edge_count + 16'd1;
    end
  end

  // Rejected-glitch counter, saturating so a noisy line cannot wrap it back to a small value.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_glitch_count <= 8'd0;
    end else if (io_ear.clear_count) begin
      r_glitch_count <= 8'd0;
    end else if (w_glitch && (r_glitch_count != 8'hFF)) begin
      r_glitch_count <= r_glitch_count + 8'd1;
    end
  end

  // Activity stretcher: restart on each edge, count up until the msb sets, then park.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_acnt <= ACNT_IDLE;
    end else if (r_ear_edge) begin
      r_acnt <= '0;
    end else if (!r_acnt[ACT_HOLD_BITS-1]) begin
      r_acnt <= r_acnt + ACNT_ONE;
    end
  end

  assign io_ear.ear_out      = r_ear_out;
  assign io_ear.ear_edge     = r_ear_edge;
  assign io_ear.edge_count   = r_edge_count;
  assign io_ear.glitch_count = r_glitch_count;
  assign io_ear.activity     = ~r_acnt[ACT_HOLD_BITS-1];

endmodule

// File: tb/tb_ear_input_conditioner.sv
// Purpose: self-checking bench for ear_input_conditioner (FILTER_CYCLES 8 and 1, short activity hold).
// Latency: outputs sampled on the falling clock edge, inputs driven there too.
// Backpressure: none; stimulus is free-running.
`timescale 1ns/1ps
module tb_ear_input_conditioner;

  localparam int HOLD = 32;  // 2^(ACT_HOLD_BITS-1) with ACT_HOLD_BITS=6

  logic clk28 = 1'b0;
  logic rst   = 1'b1;
  logic chk_en = 1'b0;

  always #5 clk28 = ~clk28;

  ear_input_conditioner_if if0();
  ear_input_conditioner_if if1();

  ear_input_conditioner #(.INVERT(1'b1), .FILTER_CYCLES(8), .ACT_HOLD_BITS(6)) u0 (
    .clk28  (clk28),
    .rst    (rst),
    .io_ear (if0)
  );

  ear_input_conditioner #(.INVERT(1'b1), .FILTER_CYCLES(1), .ACT_HOLD_BITS(6)) u1 (
    .clk28  (clk28),
    .rst    (rst),
    .io_ear (if1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: pin samples from the last two edges, the accepted level, the
  // length of the current disagreeing run, event counts and the time of the
  // most recent edge pulse. Activity is "last edge pulse less than HOLD cycles ago".
  int   fc_len [2] = '{8, 1};
  logic h_old [2];
  logic h_new [2];
  logic m_out [2];
  logic m_edge [2];
  logic m_act [2];
  int   m_run [2];
  int   m_ec [2];
  int   m_gc [2];
  int   m_last [2];
  int   cyc = 0;

  task automatic model_reset(input int i);
    h_old[i]  = 1'b0;
    h_new[i]  = 1'b0;
    m_out[i]  = 1'b0;
    m_edge[i] = 1'b0;
    m_act[i]  = 1'b0;
    m_run[i]  = 0;
    m_ec[i]   = 0;
    m_gc[i]   = 0;
    m_last[i] = -1000000;
  endtask

  task automatic model_step(input int i, input logic pin, input logic clr);
    logic s;
    logic glitch;
    s = ~h_old[i];
    h_old[i] = h_new[i];
    h_new[i] = pin;
    if (m_edge[i]) m_last[i] = cyc;
    if (clr) m_ec[i] = 0;
    else if (m_edge[i]) m_ec[i] = (m_ec[i] + 1) % 65536;
    glitch = 1'b0;
    if (s != m_out[i]) begin
      m_run[i] = m_run[i] + 1;
      if (m_run[i] == fc_len[i]) begin
        m_out[i]  = s;
        m_edge[i] = 1'b1;
        m_run[i]  = 0;
      end else begin
        m_edge[i] = 1'b0;
      end
    end else begin
      glitch    = (m_run[i] > 0);
      m_run[i]  = 0;
      m_edge[i] = 1'b0;
    end
    if (clr) m_gc[i] = 0;
    else if (glitch && m_gc[i] < 255) m_gc[i] = m_gc[i] + 1;
    m_act[i] = (cyc - m_last[i]) < HOLD;
  endtask

  function automatic logic [31:0] model_pack(input int i);
    return {5'd0, 8'(m_gc[i]), 16'(m_ec[i]), m_act[i], m_edge[i], m_out[i]};
  endfunction

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk28 or posedge rst);
      if (rst) begin
        model_reset(0);
        model_reset(1);
      end else begin
        cyc++;
        model_step(0, if0.ear_pin, if0.clear_count);
        model_step(1, if1.ear_pin, if1.clear_count);
      end
    end
  end

  // Continuous comparison of all outputs against the model.
  initial forever begin
    @(negedge clk28);
    if (chk_en && !rst) begin
      check("model_u0", {5'd0, if0.glitch_count, if0.edge_count, if0.activity, if0.ear_edge, if0.ear_out}, model_pack(0));
      check("model_u1", {5'd0, if1.glitch_count, if1.edge_count, if1.activity, if1.ear_edge, if1.ear_out}, model_pack(1));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // ---------------- directed + table + random stimulus ----------------
  typedef struct {
    int   width;
    logic mid_out;
    int   edges;
    int   glitches;
  } pulse_vec_t;

  pulse_vec_t vecs [6];
  int hold0;
  int hold1;

  task automatic clear_both();
    @(negedge clk28);
    if0.clear_count = 1'b1;
    if1.clear_count = 1'b1;
    @(negedge clk28);
    if0.clear_count = 1'b0;
    if1.clear_count = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1,  1'b0, 0, 1};
    vecs[1] = '{2,  1'b0, 0, 1};
    vecs[2] = '{7,  1'b0, 0, 1};
    vecs[3] = '{8,  1'b1, 2, 0};
    vecs[4] = '{9,  1'b1, 2, 0};
    vecs[5] = '{15, 1'b1, 2, 0};

    if0.ear_pin = 1'b1;  if0.clear_count = 1'b0;
    if1.ear_pin = 1'b1;  if1.clear_count = 1'b0;

    // Reset held while the pins toggle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk28);
      if0.ear_pin = ~if0.ear_pin;
      if1.ear_pin = ~if1.ear_pin;
    end
    check("rst_out0",  32'(if0.ear_out), 32'd0);
    check("rst_edge0", 32'(if0.ear_edge), 32'd0);
    check("rst_ecnt0", 32'(if0.edge_count), 32'd0);
    check("rst_gcnt0", 32'(if0.glitch_count), 32'd0);
    check("rst_act0",  32'(if0.activity), 32'd0);
    check("rst_out1",  32'(if1.ear_out), 32'd0);
    check("rst_edge1", 32'(if1.ear_edge), 32'd0);
    check("rst_ecnt1", 32'(if1.edge_count), 32'd0);
    check("rst_gcnt1", 32'(if1.glitch_count), 32'd0);
    check("rst_act1",  32'(if1.activity), 32'd0);
    if0.ear_pin = 1'b1;
    if1.ear_pin = 1'b1;
    @(negedge clk28);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (45) @(negedge clk28);
    clear_both();

    // Clean steps; u0 returns at edge 21 (second edge 20 cycles after the first), u1 at edge 51.
    if0.ear_pin = 1'b0;
    if1.ear_pin = 1'b0;
    for (int j = 1; j <= 90; j++) begin
      @(negedge clk28);
      check("step_out0",  32'(if0.ear_out), 32'(j >= 10 && j < 30));
      check("step_edge0", 32'(if0.ear_edge), 32'(j == 10 || j == 30));
      check("step_ecnt0", 32'(if0.edge_count), (j >= 31) ? 32'd2 : (j >= 11) ? 32'd1 : 32'd0);
      check("step_act0",  32'(if0.activity), 32'(j >= 11 && j <= 62));
      check("step_out1",  32'(if1.ear_out), 32'(j >= 3 && j < 53));
      check("step_edge1", 32'(if1.ear_edge), 32'(j == 3 || j == 53));
      check("step_act1",  32'(if1.activity), 32'((j >= 4 && j <= 35) || (j >= 54 && j <= 85)));
      if (j == 20) if0.ear_pin = 1'b1;
      if (j == 50) if1.ear_pin = 1'b1;
    end

    // Pulse-width table on u0.
    for (int v = 0; v < 6; v++) begin
      clear_both();
      if0.ear_pin = 1'b0;
      for (int j = 1; j <= vecs[v].width + 22; j++) begin
        @(negedge clk28);
        if (j == vecs[v].width) if0.ear_pin = 1'b1;
        if (j == vecs[v].width + 2) check("pulse_mid_out", 32'(if0.ear_out), 32'(vecs[v].mid_out));
      end
      check("pulse_edges",    32'(if0.edge_count), 32'(vecs[v].edges));
      check("pulse_glitches", 32'(if0.glitch_count), 32'(vecs[v].glitches));
      check("pulse_out_idle", 32'(if0.ear_out), 32'd0);
    end

    // Glitch counter saturation on u0.
    clear_both();
    for (int i = 1; i <= 300; i++) begin
      if0.ear_pin = 1'b0;
      repeat (2) @(negedge clk28);
      if0.ear_pin = 1'b1;
      repeat (4) @(negedge clk28);
      if (i == 254) check("glitch_254", 32'(if0.glitch_count), 32'h0FE);
    end
    check("glitch_sat", 32'(if0.glitch_count), 32'h0FF);
    check("glitch_out", 32'(if0.ear_out), 32'd0);

    // Edge counter wrap on u1: with one-cycle filtering each pin toggle is one edge.
    clear_both();
    chk_en = 1'b0;
    for (int k = 0; k < 65535; k++) begin
      if1.ear_pin = ~if1.ear_pin;
      @(negedge clk28);
    end
    repeat (5) @(negedge clk28);
    check("wrap_ffff", 32'(if1.edge_count), 32'h0FFFF);
    if1.ear_pin = ~if1.ear_pin;
    repeat (5) @(negedge clk28);
    check("wrap_zero", 32'(if1.edge_count), 32'd0);
    if1.ear_pin = ~if1.ear_pin;
    repeat (5) @(negedge clk28);
    check("wrap_one", 32'(if1.edge_count), 32'd1);
    // Clear coincident with an edge pulse.
    if1.ear_pin = ~if1.ear_pin;
    repeat (3) @(negedge clk28);
    check("coinc_edge", 32'(if1.ear_edge), 32'd1);
    if1.clear_count = 1'b1;
    @(negedge clk28);
    if1.clear_count = 1'b0;
    check("coinc_clear", 32'(if1.edge_count), 32'd0);
    repeat (3) @(negedge clk28);
    check("coinc_after", 32'(if1.edge_count), 32'd0);
    chk_en = 1'b1;

    // Reset in the middle of a mismatch run on u0.
    clear_both();
    if0.ear_pin = 1'b0;
    repeat (7) @(negedge clk28);
    rst = 1'b1;
    #1;
    check("midrst_out",  32'(if0.ear_out), 32'd0);
    check("midrst_gcnt", 32'(if0.glitch_count), 32'd0);
    check("midrst_ecnt", 32'(if0.edge_count), 32'd0);
    @(negedge clk28);
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk28);
      if (j <= 7) check("midrst_hold", 32'(if0.ear_out), 32'd0);
      if (j >= 10) check("midrst_acc", 32'(if0.ear_out), 32'd1);
      check("midrst_glitch", 32'(if0.glitch_count), 32'd0);
    end

    // Random pin activity and occasional clears, checked against the model.
    hold0 = 1;
    hold1 = 1;
    for (int k = 0; k < 4000; k++) begin
      hold0--;
      if (hold0 == 0) begin
        if0.ear_pin = ~if0.ear_pin;
        hold0 = $urandom_range(1, 12);
      end
      hold1--;
      if (hold1 == 0) begin
        if1.ear_pin = ~if1.ear_pin;
        hold1 = $urandom_range(1, 3);
      end
      if0.clear_count = ($urandom_range(0, 63) == 0);
      if1.clear_count = ($urandom_range(0, 63) == 0);
      @(negedge clk28);
    end
    if0.clear_count = 1'b0;
    if1.clear_count = 1'b0;
    repeat (40) @(negedge clk28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
